// File: rtl/cache_line_xfer_ctrl_pkg.sv
// Shared definitions for the cache data RAM line transfer controller:
// default geometry, FSM state encoding and the line-alignment helper.
package cache_line_xfer_ctrl_pkg;

   localparam int unsigned RAM_AW     = 5;
   localparam int unsigned LINE_WORDS = 2;

   typedef enum logic [3:0] {
      IDLE,
      WB_REQ,
      WB_RD,
      WB_LAT,
      WB_DATA,
      WB_RESP,
      RF_REQ,
      RF_DATA,
      DONE
   } xfer_state_t;

   // Clears the byte-offset bits of a line of 'words' 64-bit words.
   function automatic logic [31:0] line_align(input logic [31:0] addr, input int unsigned words);
      logic [31:0] mask;
      mask = 32'(words * 8) - 32'd1;
      return addr & ~mask;
   endfunction

endpackage

// File: rtl/cache_line_xfer_ctrl.sv
// Miss-service controller on the data RAM port: optional victim writeback
// (RAM read -> memory write burst) followed by a line refill (read burst -> RAM).
module cache_line_xfer_ctrl
   import cache_line_xfer_ctrl_pkg::*;
#(
   parameter int unsigned RAM_AW     = cache_line_xfer_ctrl_pkg::RAM_AW,
   parameter int unsigned LINE_WORDS = cache_line_xfer_ctrl_pkg::LINE_WORDS,
   parameter int unsigned SET_W      = RAM_AW - $clog2(LINE_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wb,
   input  logic [SET_W-1:0]  req_set,
   input  logic [31:0]       req_wb_addr,
   input  logic [31:0]       req_rf_addr,
   output logic              done,
   output logic              done_err,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [63:0]       ram_wdata,
   output logic              ram_we,
   input  logic [63:0]       ram_rdata,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_write,
   output logic [31:0]       mem_req_addr,
   output logic              mem_wvalid,
   input  logic              mem_wready,
   output logic [63:0]       mem_wdata,
   output logic              mem_wlast,
   input  logic              mem_bvalid,
   input  logic              mem_rvalid,
   output logic              mem_rready,
   input  logic [63:0]       mem_rdata,
   input  logic              mem_rlast
);

   localparam int unsigned      CNT_W    = $clog2(LINE_WORDS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

   xfer_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [SET_W-1:0] set_q;
   logic [31:0]      wb_addr_q;
   logic [31:0]      rf_addr_q;
   logic [63:0]      wbuf;
   logic             err_q;
   logic             cnt_last;

   assign cnt_last = (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         err_q     <= 1'b0;
         set_q     <= '0;
         wb_addr_q <= '0;
         rf_addr_q <= '0;
         wbuf      <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               set_q     <= req_set;
               wb_addr_q <= req_wb_addr;
               rf_addr_q <= req_rf_addr;
               cnt       <= '0;
               err_q     <= 1'b0;
               state     <= req_wb ? WB_REQ : RF_REQ;
            end
            WB_REQ:  if (mem_req_ready) state <= WB_RD;
            WB_RD:   state <= WB_LAT;
            WB_LAT: begin
               wbuf  <= ram_rdata;
               state <= WB_DATA;
            end
            // cnt + 1 wraps back to zero after the last word of the line.
            WB_DATA: if (mem_wready) begin
               cnt   <= cnt + 1'b1;
               state <= cnt_last ? WB_RESP : WB_RD;
            end
            WB_RESP: if (mem_bvalid) state <= RF_REQ;
            RF_REQ:  if (mem_req_ready) state <= RF_DATA;
            RF_DATA: if (mem_rvalid) begin
               if (mem_rlast != cnt_last) err_q <= 1'b1;
               cnt <= cnt + 1'b1;
               if (cnt_last) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready     = (state == IDLE);
   assign mem_req_valid = (state == WB_REQ) || (state == RF_REQ);
   assign mem_req_write = (state == WB_REQ);
   assign mem_req_addr  = (state == WB_REQ) ? line_align(wb_addr_q, LINE_WORDS) :
                          (state == RF_REQ) ? line_align(rf_addr_q, LINE_WORDS) : '0;
   assign mem_wvalid    = (state == WB_DATA);
   assign mem_wdata     = (state == WB_DATA) ? wbuf : '0;
   assign mem_wlast     = (state == WB_DATA) && cnt_last;
   assign mem_rready    = (state == RF_DATA);
   assign ram_addr      = {set_q, cnt};
   assign ram_we        = (state == RF_DATA) && mem_rvalid;
   assign ram_wdata     = ram_we ? mem_rdata : '0;
   assign done          = (state == DONE);
   assign done_err      = (state == DONE) && err_q;

endmodule
